clock_logic_serializer_1: RTL and testbench
===========================================

Name: clock_logic_serializer_1

Overview:
Parallel-in, serial-out shifter. It is the transmit-side counterpart of the clock_logic delay/shift chains: it accepts a WIDTH-bit word over a valid/ready handshake and drives it one bit per clock on data_out, with framing strobes for the downstream receiver. The line rests at IDLE_LEVEL between words. Single clock domain.

Parameters:
WIDTH, 4, word length in bits; legal range 1..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
IDLE_LEVEL, 1, value of data_out when no bit is being sent.
GAP, 0, number of idle cycles forced after each word; legal range 0..255.

Ports:
clock  input  1  rising-edge clock
resetn  input  1  asynchronous, active-low reset
load_valid  input  1  upstream has a word on load_data
load_ready  output  1  block can accept a word this cycle (combinational from state)
load_data  input  WIDTH  word to serialize; sampled only on the accept edge
data_out  output  1  serial bit; registered
data_valid  output  1  data_out carries a word bit; registered
frame_start  output  1  high with the first bit of each word; registered
frame_done  output  1  high with the last bit of each word; registered
busy  output  1  high in SHIFT or GAP state

Behaviour:
- Reset is asynchronous, active-low, on resetn; clock is clock. The reset is applied immediately, including mid-word, and the partial word is discarded.
- Reset values: state=IDLE, data_out=IDLE_LEVEL, data_valid=0, frame_start=0, frame_done=0, busy=0, shift register=all IDLE_LEVEL, counters=0.
- States:
  - IDLE: wait for a word.
  - SHIFT: bits are being sent; bit counter cnt counts down from WIDTH-1 to 0.
  - GAP: forced idle; gap counter counts down from GAP-1 to 0.
- load_ready is high in either of these cases:
  - state==IDLE;
  - state==SHIFT && cnt==0 && GAP==0, which allows back-to-back words.
- Accept happens on a clock edge where load_valid && load_ready. On accept:
  - data_out <= first bit; shift register <= remaining bits;
  - cnt <= WIDTH-1; data_valid <= 1; frame_start <= 1;
  - frame_done <= (WIDTH==1); state <= SHIFT.
- Latency: the first bit is visible in the cycle immediately after the accept edge. Word bits occupy WIDTH consecutive cycles with data_valid=1.
- SHIFT with cnt>0, at each edge:
  - shift out the next bit; cnt <= cnt-1; frame_start <= 0;
  - frame_done <= (cnt==1).
- SHIFT with cnt==0, at the edge ending the last bit:
  - Accept (GAP==0 only): reload per accept rules. Result is no idle cycle and a contiguous bit stream.
  - Else if GAP>0: state <= GAP; data_out <= IDLE_LEVEL; data_valid, frame_start and frame_done <= 0.
  - Else: state <= IDLE with the same output clears.
- GAP: load_ready=0 and data_out=IDLE_LEVEL. Exit to IDLE when the gap counter reaches 0, giving exactly GAP idle cycles.
- load_data is ignored whenever load_ready=0. Changes on load_data during SHIFT do not affect the word in flight.
- busy = (state != IDLE), registered with the state.
- WIDTH==1: frame_start and frame_done are high in the same single cycle.
- No underflow handling is required. data_valid simply drops when no word is pending.

Test Plan:
- WIDTH=4, MSB_FIRST=1: load 4'b1010 → data_out 1,0,1,0 on cycles 1-4 after accept with data_valid=1; frame_start on cycle 1 only; frame_done on cycle 4 only; load_ready=0 on cycles 1-3; data_out=1 and data_valid=0 afterwards.
- MSB_FIRST=0: load 4'b0011 → data_out 1,1,0,0; frame strobes on cycles 1 and 4.
- GAP=0, load_valid held with 4'hA then 4'h5 → 8 contiguous data_valid cycles carrying 1,0,1,0,0,1,0,1; frame_start on cycles 1 and 5; frame_done on cycles 4 and 8.
- GAP=2, two words queued → after the last bit of word 1: 2 cycles with data_out=1, data_valid=0, load_ready=0, busy=1; word 2's first bit appears 4 cycles after word 1's last bit (cycle of ready, accept edge, then first bit).
- Reset asserted after 2 bits of 4'b0110 → data_out=1, data_valid=0, busy=0 asynchronously; after release load_ready=1 and a new word 4'b1001 serializes cleanly as 1,0,0,1.
- WIDTH=1, load 1'b0 with load_valid held low afterwards → one cycle with data_out=0, data_valid=1, frame_start=1, frame_done=1; then IDLE.

Source files
------------

// File: rtl/clock_logic_serializer_1.sv
// Parallel-in, serial-out shifter: accepts a WIDTH-bit word over valid/ready
// and sends it one bit per clock with first/last framing strobes.
module clock_logic_serializer_1 #(
  parameter int WIDTH      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int IDLE_LEVEL = 1,
  parameter int GAP        = 0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             data_out,
  output logic             data_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic             IDLE_BIT  = (IDLE_LEVEL != 0) ? 1'b1 : 1'b0;
  localparam logic [WIDTH-1:0] IDLE_WORD = {WIDTH{IDLE_BIT}};
  localparam logic [WIDTH-1:0] FILL_LO   = IDLE_BIT ? WIDTH'(1'b1) : WIDTH'(1'b0);
  localparam logic [WIDTH-1:0] FILL_HI   = FILL_LO << (WIDTH - 1);
  localparam logic [4:0]       LAST_CNT  = 5'(WIDTH - 1);
  localparam logic [7:0]       GAP_LOAD  = 8'(GAP - 1);
  localparam bit               HAS_GAP   = (GAP != 0);
  localparam bit               ONE_BIT   = (WIDTH == 1);

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [4:0]       cnt_q;
  logic [7:0]       gap_q;
  logic             data_out_q;
  logic             data_valid_q;
  logic             frame_start_q;
  logic             frame_done_q;
  logic             busy_q;
  logic             accept_s;

  // Bit that leaves the word first (or the next bit held in the shift register).
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Drop the head bit and back-fill with the idle level.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) begin
      return (w << 1) | FILL_LO;
    end else begin
      return (w >> 1) | FILL_HI;
    end
  endfunction

  // The last-bit cycle may take the next word directly only when no gap is forced.
  assign load_ready = (state_q == S_IDLE) ||
                      ((state_q == S_SHIFT) && (cnt_q == 5'd0) && !HAS_GAP);
  assign accept_s   = load_valid && load_ready;

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

  // Serializer FSM with registered line outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      shreg_q       <= IDLE_WORD;
      cnt_q         <= 5'd0;
      gap_q         <= 8'd0;
      data_out_q    <= IDLE_BIT;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else if (accept_s) begin
      state_q       <= S_SHIFT;
      data_out_q    <= head_bit(load_data);
      shreg_q       <= advance(load_data);
      cnt_q         <= LAST_CNT;
      data_valid_q  <= 1'b1;
      frame_start_q <= 1'b1;
      frame_done_q  <= ONE_BIT;
      busy_q        <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          data_out_q    <= IDLE_BIT;
          data_valid_q  <= 1'b0;
          frame_start_q <= 1'b0;
          frame_done_q  <= 1'b0;
          busy_q        <= 1'b0;
        end
        S_SHIFT: begin
          if (cnt_q != 5'd0) begin
            data_out_q    <= head_bit(shreg_q);
            shreg_q       <= advance(shreg_q);
            cnt_q         <= cnt_q - 5'd1;
            frame_start_q <= 1'b0;
            frame_done_q  <= (cnt_q == 5'd1);
          end else begin
            state_q       <= HAS_GAP ? S_GAP : S_IDLE;
            gap_q         <= GAP_LOAD;
            data_out_q    <= IDLE_BIT;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= HAS_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == 8'd0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          data_out_q    <= IDLE_BIT;
          data_valid_q  <= 1'b0;
          frame_start_q <= 1'b0;
          frame_done_q  <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_logic_serializer_1.sv
// Directed bench: four serializer configurations driven from one vector table,
// plus a hand-written mid-word asynchronous reset sequence.
module tb_clock_logic_serializer_1;

  typedef struct {
    int         inst;
    logic       lv;
    logic [3:0] ld;
    logic [5:0] exp;   // {data_out, data_valid, frame_start, frame_done, load_ready, busy}
  } vec_t;

  logic       clock;
  logic       resetn;
  logic [3:0] lv_s;
  logic [3:0] ld_s [4];
  logic [3:0] dout_s, dv_s, fs_s, fd_s, rdy_s, busy_s;

  int   n_chk;
  int   n_err;
  vec_t tbl[$];

  // inst 0: WIDTH=4 MSB first, no gap
  clock_logic_serializer_1 #(.WIDTH(4), .MSB_FIRST(1), .IDLE_LEVEL(1), .GAP(0)) u_a (
    .clock(clock), .resetn(resetn), .load_valid(lv_s[0]), .load_ready(rdy_s[0]),
    .load_data(ld_s[0]), .data_out(dout_s[0]), .data_valid(dv_s[0]),
    .frame_start(fs_s[0]), .frame_done(fd_s[0]), .busy(busy_s[0]));

  // inst 1: WIDTH=4 LSB first
  clock_logic_serializer_1 #(.WIDTH(4), .MSB_FIRST(0), .IDLE_LEVEL(1), .GAP(0)) u_b (
    .clock(clock), .resetn(resetn), .load_valid(lv_s[1]), .load_ready(rdy_s[1]),
    .load_data(ld_s[1]), .data_out(dout_s[1]), .data_valid(dv_s[1]),
    .frame_start(fs_s[1]), .frame_done(fd_s[1]), .busy(busy_s[1]));

  // inst 2: WIDTH=4 MSB first, two forced idle cycles
  clock_logic_serializer_1 #(.WIDTH(4), .MSB_FIRST(1), .IDLE_LEVEL(1), .GAP(2)) u_c (
    .clock(clock), .resetn(resetn), .load_valid(lv_s[2]), .load_ready(rdy_s[2]),
    .load_data(ld_s[2]), .data_out(dout_s[2]), .data_valid(dv_s[2]),
    .frame_start(fs_s[2]), .frame_done(fd_s[2]), .busy(busy_s[2]));

  // inst 3: single-bit words
  clock_logic_serializer_1 #(.WIDTH(1), .MSB_FIRST(1), .IDLE_LEVEL(1), .GAP(0)) u_d (
    .clock(clock), .resetn(resetn), .load_valid(lv_s[3]), .load_ready(rdy_s[3]),
    .load_data(ld_s[3][0]), .data_out(dout_s[3]), .data_valid(dv_s[3]),
    .frame_start(fs_s[3]), .frame_done(fd_s[3]), .busy(busy_s[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int i, input logic [5:0] e);
    chk({tag, " data_out"},    dout_s[i], e[5]);
    chk({tag, " data_valid"},  dv_s[i],   e[4]);
    chk({tag, " frame_start"}, fs_s[i],   e[3]);
    chk({tag, " frame_done"},  fd_s[i],   e[2]);
    chk({tag, " load_ready"},  rdy_s[i],  e[1]);
    chk({tag, " busy"},        busy_s[i], e[0]);
  endtask

  task automatic add(input int i, input logic v, input logic [3:0] d, input logic [5:0] e);
    vec_t t;
    t.inst = i; t.lv = v; t.ld = d; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    lv_s = 4'b0000;
    lv_s[v.inst] = v.lv;
    ld_s[v.inst] = v.ld;
    @(posedge clock);
    #1;
    chk_outs(tag, v.inst, v.exp);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    resetn = 1'b0;
    lv_s = 4'b0000;
    for (int i = 0; i < 4; i++) ld_s[i] = 4'h0;

    // inst 0: single word 1010, then back-to-back A,5 with load_valid held
    add(0, 1'b1, 4'hA, 6'b111001);
    add(0, 1'b0, 4'h0, 6'b010001);
    add(0, 1'b0, 4'h0, 6'b110001);
    add(0, 1'b0, 4'h0, 6'b010111);
    add(0, 1'b0, 4'h0, 6'b100010);
    add(0, 1'b1, 4'hA, 6'b111001);
    add(0, 1'b1, 4'h5, 6'b010001);
    add(0, 1'b1, 4'h5, 6'b110001);
    add(0, 1'b1, 4'h5, 6'b010111);
    add(0, 1'b1, 4'h5, 6'b011001);
    add(0, 1'b0, 4'hF, 6'b110001);
    add(0, 1'b0, 4'hF, 6'b010001);
    add(0, 1'b0, 4'hF, 6'b110111);
    add(0, 1'b0, 4'h0, 6'b100010);
    // inst 1: LSB first, 0011 -> 1,1,0,0
    add(1, 1'b1, 4'h3, 6'b111001);
    add(1, 1'b0, 4'h0, 6'b110001);
    add(1, 1'b0, 4'h0, 6'b010001);
    add(1, 1'b0, 4'h0, 6'b010111);
    add(1, 1'b0, 4'h0, 6'b100010);
    // inst 2: GAP=2, words C then 3 queued
    add(2, 1'b1, 4'hC, 6'b111001);
    add(2, 1'b1, 4'h3, 6'b110001);
    add(2, 1'b1, 4'h3, 6'b010001);
    add(2, 1'b1, 4'h3, 6'b010101);
    add(2, 1'b1, 4'h3, 6'b100001);
    add(2, 1'b1, 4'h3, 6'b100001);
    add(2, 1'b1, 4'h3, 6'b100010);
    add(2, 1'b1, 4'h3, 6'b011001);
    add(2, 1'b0, 4'h0, 6'b010001);
    add(2, 1'b0, 4'h0, 6'b110001);
    add(2, 1'b0, 4'h0, 6'b110101);
    add(2, 1'b0, 4'h0, 6'b100001);
    add(2, 1'b0, 4'h0, 6'b100001);
    add(2, 1'b0, 4'h0, 6'b100010);
    // inst 3: WIDTH=1, word 0
    add(3, 1'b1, 4'h0, 6'b011111);
    add(3, 1'b0, 4'h0, 6'b100010);

    #12;
    for (int i = 0; i < 4; i++) chk_outs($sformatf("reset inst%0d", i), i, 6'b100010);
    @(negedge clock);
    resetn = 1'b1;

    foreach (tbl[k]) run_vec(tbl[k], $sformatf("v%0d inst%0d", k, tbl[k].inst));

    // mid-word reset: two bits of 0110 out, then async reset, then 1001
    run_vec('{0, 1'b1, 4'h6, 6'b011001}, "rst w1 b0");
    run_vec('{0, 1'b0, 4'h0, 6'b110001}, "rst w1 b1");
    #3;
    resetn = 1'b0;
    #1;
    chk_outs("async reset", 0, 6'b100010);
    resetn = 1'b1;
    #1;
    chk("post reset load_ready", rdy_s[0], 1'b1);
    run_vec('{0, 1'b1, 4'h9, 6'b111001}, "rst w2 b0");
    run_vec('{0, 1'b0, 4'h0, 6'b010001}, "rst w2 b1");
    run_vec('{0, 1'b0, 4'h0, 6'b010001}, "rst w2 b2");
    run_vec('{0, 1'b0, 4'h0, 6'b110111}, "rst w2 b3");
    run_vec('{0, 1'b0, 4'h0, 6'b100010}, "rst w2 idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
